// File: rtl/duplex_if.sv
// Host-side bus of the duplex UART loopback block: transmit request and
// configuration in one direction, status flags and received byte in the other.
interface duplex_if;
    logic       send;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_in;
    logic       tx_active_flag;
    logic       tx_done_flag;
    logic       rx_active_flag;
    logic       rx_done_flag;
    logic [2:0] error_flag;
    logic [7:0] data_out;

    modport master (
        output send, parity_type, baud_rate, data_in,
        input  tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag,
        input  error_flag, data_out
    );

    modport slave (
        input  send, parity_type, baud_rate, data_in,
        output tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag,
        output error_flag, data_out
    );
endinterface

// File: rtl/duplex.sv
// Full-duplex UART loopback: an 8-bit transmitter drives an internal serial
// line that feeds an on-chip receiver. Frame is start, D0..D7 LSB first,
// parity slot, stop (11 bits). Optional macro DUPLEX_RX_SYNC_EN inserts a
// 2-flop synchronizer on the receiver input (+2 clk of RX latency).
module duplex #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic     clk,
    input  logic     rst_n,
    duplex_if.slave  bus
);

    localparam logic [14:0] DIV_2400  = 15'((CLK_FREQ + 1200) / 2400);
    localparam logic [14:0] DIV_4800  = 15'((CLK_FREQ + 2400) / 4800);
    localparam logic [14:0] DIV_9600  = 15'((CLK_FREQ + 4800) / 9600);
    localparam logic [14:0] DIV_19200 = 15'((CLK_FREQ + 9600) / 19200);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Clocks per bit for the selected baud rate.
    function automatic logic [14:0] div_sel(input logic [1:0] br);
        logic [14:0] d;
        case (br)
            2'b00:   d = DIV_2400;
            2'b01:   d = DIV_4800;
            2'b10:   d = DIV_9600;
            2'b11:   d = DIV_19200;
            default: d = DIV_2400;
        endcase
        return d;
    endfunction

    // Value carried in the parity slot; modes without parity send a 1.
    function automatic logic par_bit(input logic [7:0] d, input logic [1:0] pt);
        logic p;
        case (pt)
            2'b01:   p = ~^d;
            2'b10:   p = ^d;
            default: p = 1'b1;
        endcase
        return p;
    endfunction

    // Transmitter state; the frame configuration it latches is shared with RX.
    state_t      tx_state_q;
    logic [14:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_pbit_q;
    logic        tx_line_q;
    logic        tx_active_q;
    logic        tx_done_q;
    logic [1:0]  cfg_par_q;
    logic [14:0] cfg_div_q;

    // Receiver state.
    state_t      rx_state_q;
    logic [14:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_par_q;
    logic        rx_prev_q;
    logic        rx_active_q;
    logic        rx_done_q;
    logic [2:0]  err_q;
    logic [7:0]  data_q;

    logic        rx_in_s;
    logic        tx_tick_s;
    logic        rx_tick_s;
    logic        rx_half_s;
    logic        par_err_s;

    assign tx_tick_s = (tx_cnt_q == cfg_div_q - 15'd1);
    assign rx_tick_s = (rx_cnt_q == cfg_div_q - 15'd1);
    assign rx_half_s = (rx_cnt_q == {1'b0, cfg_div_q[14:1]} - 15'd1);
    assign par_err_s = ((cfg_par_q == 2'b01) || (cfg_par_q == 2'b10)) &&
                       (rx_par_q != par_bit(rx_shift_q, cfg_par_q));

`ifdef DUPLEX_RX_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer on the receive line, idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= tx_line_q;
            sync2_q <= sync1_q;
        end
    end

    assign rx_in_s = sync2_q;
`else
    assign rx_in_s = tx_line_q;
`endif

    // Transmit FSM: latch config on send, then shift out one bit every divisor period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= 15'd0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            tx_pbit_q   <= 1'b1;
            tx_line_q   <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
            cfg_par_q   <= 2'b00;
            cfg_div_q   <= DIV_2400;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                S_IDLE: begin
                    if (bus.send) begin
                        tx_shift_q  <= bus.data_in;
                        cfg_par_q   <= bus.parity_type;
                        cfg_div_q   <= div_sel(bus.baud_rate);
                        tx_pbit_q   <= par_bit(bus.data_in, bus.parity_type);
                        tx_line_q   <= 1'b0;
                        tx_active_q <= 1'b1;
                        tx_cnt_q    <= 15'd0;
                        tx_state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_tick_s) begin
                        tx_cnt_q   <= 15'd0;
                        tx_bit_q   <= 3'd0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 15'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tick_s) begin
                        tx_cnt_q <= 15'd0;
                        if (tx_bit_q == 3'd7) begin
                            tx_line_q  <= tx_pbit_q;
                            tx_state_q <= S_PARITY;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_line_q  <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 15'd1;
                    end
                end
                S_PARITY: begin
                    if (tx_tick_s) begin
                        tx_cnt_q   <= 15'd0;
                        tx_line_q  <= 1'b1;
                        tx_state_q <= S_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 15'd1;
                    end
                end
                S_STOP: begin
                    if (tx_tick_s) begin
                        tx_cnt_q    <= 15'd0;
                        tx_active_q <= 1'b0;
                        tx_done_q   <= 1'b1;
                        tx_state_q  <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 15'd1;
                    end
                end
                default: begin
                    tx_state_q  <= S_IDLE;
                    tx_line_q   <= 1'b1;
                    tx_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Receive FSM: find the start edge, sample at bit centres, publish byte and errors at stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= 15'd0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_par_q    <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_active_q <= 1'b0;
            rx_done_q   <= 1'b0;
            err_q       <= 3'b000;
            data_q      <= 8'd0;
        end else begin
            rx_prev_q <= rx_in_s;
            rx_done_q <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_in_s) begin
                        rx_cnt_q    <= 15'd0;
                        rx_active_q <= 1'b1;
                        rx_state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (rx_half_s) begin
                        rx_cnt_q <= 15'd0;
                        if (rx_in_s) begin
                            err_q[1]    <= 1'b1;
                            rx_active_q <= 1'b0;
                            rx_state_q  <= S_IDLE;
                        end else begin
                            rx_bit_q   <= 3'd0;
                            rx_state_q <= S_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 15'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick_s) begin
                        rx_cnt_q   <= 15'd0;
                        rx_shift_q <= {rx_in_s, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= S_PARITY;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 15'd1;
                    end
                end
                S_PARITY: begin
                    if (rx_tick_s) begin
                        rx_cnt_q   <= 15'd0;
                        rx_par_q   <= rx_in_s;
                        rx_state_q <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 15'd1;
                    end
                end
                S_STOP: begin
                    if (rx_tick_s) begin
                        rx_cnt_q    <= 15'd0;
                        data_q      <= rx_shift_q;
                        err_q       <= {~rx_in_s, 1'b0, par_err_s};
                        rx_done_q   <= 1'b1;
                        rx_active_q <= 1'b0;
                        rx_state_q  <= S_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 15'd1;
                    end
                end
                default: begin
                    rx_state_q  <= S_IDLE;
                    rx_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_active_flag = tx_active_q;
    assign bus.tx_done_flag   = tx_done_q;
    assign bus.rx_active_flag = rx_active_q;
    assign bus.rx_done_flag   = rx_done_q;
    assign bus.error_flag     = err_q;
    assign bus.data_out       = data_q;

endmodule

// File: tb/tb_duplex.sv
// Directed bench for the duplex UART loopback. The design runs with a reduced
// clock frequency so that divisors are 200/100/50/25 clks per bit for
// 2400/4800/9600/19200 baud.
module tb_duplex;

    localparam int CLK_FREQ = 480_000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    duplex_if bus ();

    duplex #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one frame and check line bits, TX length, RX latency and received data.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] pt,
                             input logic [1:0] br, input logic ep, input int div,
                             input logic [7:0] next_d, input bit hold);
        int          n;
        int          wait_n;
        int          tx_n;
        int          rx_n;
        logic [10:0] bits;
        logic [7:0]  rxd;
        logic [2:0]  rxe;
        logic        mid_rx_active;
        logic [10:0] exp_bits;
        int          lat;
        tx_n = -1;
        rx_n = -1;
        rxd = 8'h00;
        rxe = 3'b111;
        bits = 11'h000;
        mid_rx_active = 1'b0;
        bus.data_in     = d;
        bus.parity_type = pt;
        bus.baud_rate   = br;
        bus.send        = 1'b1;
        wait_n = 0;
        while (!bus.tx_active_flag && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_start_lat"}, 32'(wait_n), 32'd1);
        if (!hold) bus.send = 1'b0;
        n = 0;
        while (n < 12 * div + 50) begin
            if ((n % div) == (div / 2) && (n / div) < 11) bits[n / div] = dut.tx_line_q;
            if (n == 3 * div) bus.data_in = next_d;
            if (n == 5 * div) mid_rx_active = bus.rx_active_flag;
            if (bus.rx_done_flag && rx_n < 0) begin
                rx_n = n;
                rxd  = bus.data_out;
                rxe  = bus.error_flag;
            end
            if (bus.tx_done_flag) begin
                tx_n = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        exp_bits = {1'b1, ep, d, 1'b0};
        check({tag, "_frame_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_tx_len"}, 32'(tx_n), 32'(11 * div));
        lat = 10 * div + div / 2;
        check({tag, "_rx_lat"}, 32'((rx_n >= lat - 1) && (rx_n <= lat + 3)), 32'd1);
        check({tag, "_rx_active_mid"}, 32'(mid_rx_active), 32'd1);
        check({tag, "_data_out"}, 32'(rxd), 32'(d));
        check({tag, "_error_flag"}, 32'(rxe), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.send        = 1'b0;
        bus.parity_type = 2'b00;
        bus.baud_rate   = 2'b00;
        bus.data_in     = 8'h00;
        #10;
        check("rst_tx_active", 32'(bus.tx_active_flag), 32'd0);
        check("rst_tx_done",   32'(bus.tx_done_flag),   32'd0);
        check("rst_rx_active", 32'(bus.rx_active_flag), 32'd0);
        check("rst_rx_done",   32'(bus.rx_done_flag),   32'd0);
        check("rst_error",     32'(bus.error_flag),     32'd0);
        check("rst_data_out",  32'(bus.data_out),       32'd0);
        check("rst_line",      32'(dut.tx_line_q),      32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // AA has four ones: odd parity slot 1, even parity slot 0.
        run_frame("aa_odd_9600", 8'hAA, 2'b01, 2'b10, 1'b1, 50, 8'hAA, 1'b0);
        run_frame("5c_even_19200", 8'h5C, 2'b10, 2'b11, 1'b0, 25, 8'h5C, 1'b0);
        run_frame("ff_none_2400", 8'hFF, 2'b00, 2'b00, 1'b1, 200, 8'hFF, 1'b0);
        run_frame("01_none11_4800", 8'h01, 2'b11, 2'b01, 1'b1, 100, 8'h01, 1'b0);

        // Back-to-back with send held and data_in changed mid-frame.
        run_frame("b2b_first", 8'hAA, 2'b01, 2'b10, 1'b1, 50, 8'h5C, 1'b1);
        run_frame("b2b_second", 8'h5C, 2'b01, 2'b10, 1'b1, 50, 8'h5C, 1'b0);

        // Reset in the middle of the data bits.
        bus.data_in     = 8'h3C;
        bus.parity_type = 2'b10;
        bus.baud_rate   = 2'b11;
        bus.send        = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (4 * 25) @(negedge clk);
        check("midrst_pre_active", 32'(bus.tx_active_flag), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_active", 32'(bus.tx_active_flag), 32'd0);
        check("midrst_rx_active", 32'(bus.rx_active_flag), 32'd0);
        check("midrst_data_out",  32'(bus.data_out),       32'd0);
        check("midrst_error",     32'(bus.error_flag),     32'd0);
        check("midrst_line",      32'(dut.tx_line_q),      32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // 07 has three ones: odd parity slot 0.
        run_frame("07_odd_4800", 8'h07, 2'b01, 2'b01, 1'b0, 100, 8'h07, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
